// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vram_arbiter
// Description : Two-requester (CPU / video fetch) arbiter for a synchronous
//               video RAM. Video has priority unless the CPU has been passed
//               over STARVE_LIMIT times in a row. Every access is a fixed
//               IDLE -> ACCESS -> ACK sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAddr,
  input  logic [DATA_W-1:0] cpuWData,
  output logic [DATA_W-1:0] cpuRData,
  output logic              cpuAck,
  input  logic              vidReq,
  input  logic [ADDR_W-1:0] vidAddr,
  output logic [DATA_W-1:0] vidRData,
  output logic              vidAck,
  output logic              memCe,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  input  logic [DATA_W-1:0] memRData
);

  localparam int STARVE_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                own_vid_q, own_vid_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   vid_rdata_q, vid_rdata_d;

  logic w_access;
  logic w_ack;
  logic w_write;
  logic w_cpu_rd_ack;
  logic w_vid_rd_ack;

  assign w_access     = (state_q == ACCESS);
  assign w_ack        = (state_q == ACK);
  assign w_write      = w_access && !own_vid_q && we_q;
  assign w_cpu_rd_ack = w_ack && !own_vid_q && !we_q;
  assign w_vid_rd_ack = w_ack && own_vid_q;

  // Grant decision in IDLE (request fields latched here) and fixed sequencing
  always_comb begin
    state_d   = state_q;
    own_vid_d = own_vid_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    starve_d  = starve_q;
    case (state_q)
      IDLE: begin
        if (!cpuReq) begin
          starve_d = '0;
        end
        if (vidReq && !(cpuReq && (starve_q == STARVE_MAX))) begin
          state_d   = ACCESS;
          own_vid_d = 1'b1;
          addr_d    = vidAddr;
          we_d      = 1'b0;
          wdata_d   = '0;
          if (cpuReq) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
          end
        end else if (cpuReq) begin
          state_d   = ACCESS;
          own_vid_d = 1'b0;
          addr_d    = cpuAddr;
          we_d      = cpuWe;
          wdata_d   = cpuWData;
          starve_d  = '0;
        end
      end
      ACCESS:  state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Each requester's read-data register keeps its most recent read result
  always_comb begin
    cpu_rdata_d = cpu_rdata_q;
    vid_rdata_d = vid_rdata_q;
    if (w_cpu_rd_ack) begin
      cpu_rdata_d = memRData;
    end
    if (w_vid_rd_ack) begin
      vid_rdata_d = memRData;
    end
  end

  // State, latched request and read-data registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      own_vid_q   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      vid_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      own_vid_q   <= own_vid_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      vid_rdata_q <= vid_rdata_d;
    end
  end

  // RAM drive is only non-zero during ACCESS; read data bypasses during ACK
  assign memCe    = w_access;
  assign memWe    = w_write;
  assign memAddr  = w_access ? addr_q : '0;
  assign memWData = w_write ? wdata_q : '0;
  assign cpuAck   = w_ack && !own_vid_q;
  assign vidAck   = w_ack && own_vid_q;
  assign cpuRData = w_cpu_rd_ack ? memRData : cpu_rdata_q;
  assign vidRData = w_vid_rd_ack ? memRData : vid_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_vram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vram_arbiter
// Description : Self-checking bench for vram_arbiter: directed scenarios plus
//               randomized CPU/video traffic against a timestamp-based
//               transaction model with a shadow memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vram_arbiter;

  localparam int AW  = 13;
  localparam int DW  = 8;
  localparam int LIM = 4;

  logic          clk;
  logic          reset;
  logic          cpuReq, cpuWe, vidReq;
  logic [AW-1:0] cpuAddr, vidAddr, memAddr;
  logic [DW-1:0] cpuWData, cpuRData, vidRData, memWData, memRData;
  logic          cpuAck, vidAck, memCe, memWe;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .cpuReq(cpuReq), .cpuWe(cpuWe), .cpuAddr(cpuAddr), .cpuWData(cpuWData),
    .cpuRData(cpuRData), .cpuAck(cpuAck),
    .vidReq(vidReq), .vidAddr(vidAddr), .vidRData(vidRData), .vidAck(vidAck),
    .memCe(memCe), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after memCe
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (memCe) begin
      if (memWe) ram[memAddr] <= memWData;
      memRData <= ram[memAddr];
    end
  end

  // Reference model: timestamps of the current grant plus a shadow memory
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int            total, bad, cyc;
  bit            have;
  int            g_edge, next_free, starve;
  bit            own_vid, m_we, keep_vid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, exp_cpu_rd, exp_vid_rd;

  function automatic logic [DW-1:0] init_val(input int a);
    return 8'(a * 37 + 11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    have = 0; next_free = 0; starve = 0;
    exp_cpu_rd = '0; exp_vid_rd = '0;
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_cpuAck"},   32'(cpuAck),   32'd0);
    chk({pfx, "_vidAck"},   32'(vidAck),   32'd0);
    chk({pfx, "_memCe"},    32'(memCe),    32'd0);
    chk({pfx, "_memWe"},    32'(memWe),    32'd0);
    chk({pfx, "_memAddr"},  32'(memAddr),  32'd0);
    chk({pfx, "_memWData"}, 32'(memWData), 32'd0);
    chk({pfx, "_cpuRData"}, 32'(cpuRData), 32'd0);
    chk({pfx, "_vidRData"}, 32'(vidRData), 32'd0);
  endtask

  task automatic check_cycle();
    bit acc, ak, wr;
    acc = have && (cyc == g_edge);
    ak  = have && (cyc == g_edge + 1);
    wr  = acc && !own_vid && m_we;
    chk("memCe",  32'(memCe),  32'(acc));
    chk("memWe",  32'(memWe),  32'(wr));
    chk("memAddr", 32'(memAddr), acc ? 32'(m_addr) : 32'd0);
    if (!acc || wr) chk("memWData", 32'(memWData), wr ? 32'(m_wdata) : 32'd0);
    chk("cpuAck", 32'(cpuAck), 32'(ak && !own_vid));
    chk("vidAck", 32'(vidAck), 32'(ak && own_vid));
    chk("cpuRData", 32'(cpuRData), 32'(exp_cpu_rd));
    chk("vidRData", 32'(vidRData), 32'(exp_vid_rd));
  endtask

  // One clock: model the edge from the inputs it sees, check, then let the
  // requesters drop (or re-arm) on their ack.
  task automatic step();
    bit s_c, s_v, s_we;
    logic [AW-1:0] s_ca, s_va;
    logic [DW-1:0] s_wd;
    s_c = cpuReq; s_v = vidReq; s_we = cpuWe;
    s_ca = cpuAddr; s_va = vidAddr; s_wd = cpuWData;
    @(posedge clk);
    cyc++;
    if (reset) begin
      if (have && cyc == g_edge + 1) begin
        if (own_vid)   exp_vid_rd = ref_mem[m_addr];
        else if (m_we) ref_mem[m_addr] = m_wdata;
        else           exp_cpu_rd = ref_mem[m_addr];
      end
      if (cyc >= next_free) begin
        if (!s_c) starve = 0;
        if (s_v && !(s_c && starve == LIM)) begin
          own_vid = 1; m_addr = s_va; m_we = 0;
          if (s_c) starve = (starve < LIM) ? starve + 1 : LIM;
          have = 1; g_edge = cyc; next_free = cyc + 3;
        end else if (s_c) begin
          own_vid = 0; m_addr = s_ca; m_we = s_we; m_wdata = s_wd;
          starve = 0;
          have = 1; g_edge = cyc; next_free = cyc + 3;
        end
      end
    end
    #1;
    check_cycle();
    if (have && cyc == g_edge + 1) begin
      if (own_vid) begin
        if (keep_vid) vidAddr = vidAddr + 1'b1;
        else          vidReq = 1'b0;
      end else begin
        cpuReq = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 10 && (cyc + 1 < next_free); i++) step();
  endtask

  task automatic do_reset(input string pfx);
    reset = 1'b0;
    #1;
    check_zero(pfx);
    model_reset();
    cpuReq = 1'b0; vidReq = 1'b0;
    step(); step();
    reset = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0; cyc = 0; keep_vid = 0;
    own_vid = 0; m_we = 0; m_addr = '0; m_wdata = '0; g_edge = 0;
    model_reset();
    for (int i = 0; i < (1 << AW); i++) begin
      ram[i] = init_val(i); ref_mem[i] = init_val(i);
    end
    ram[13'h0123] = 8'h5A; ref_mem[13'h0123] = 8'h5A;
    reset = 1'b1; cpuReq = 0; cpuWe = 0; vidReq = 0;
    cpuAddr = '0; vidAddr = '0; cpuWData = '0;
    #2 reset = 1'b0;
    #1 check_zero("rst0");
    step(); step();
    reset = 1'b1;

    // CPU read alone
    cpuReq = 1; cpuWe = 0; cpuAddr = 13'h0123;
    step();
    chk("r034_ce", 32'(memCe), 32'd1);
    chk("r034_addr", 32'(memAddr), 32'h0123);
    cpuAddr = 13'h0555;
    step();
    chk("r034_ack", 32'(cpuAck), 32'd1);
    chk("r034_rd", 32'(cpuRData), 32'h5A);
    step(); step();
    chk("r034_hold", 32'(cpuRData), 32'h5A);

    // CPU write, then read back
    wait_idle();
    cpuReq = 1; cpuWe = 1; cpuAddr = 13'h1FFF; cpuWData = 8'hA5;
    step();
    chk("r035_we", 32'(memWe), 32'd1);
    chk("r035_wd", 32'(memWData), 32'hA5);
    cpuWData = 8'h3C; cpuWe = 0;
    step();
    chk("r035_ack", 32'(cpuAck), 32'd1);
    chk("r035_we_off", 32'(memWe), 32'd0);
    chk("r035_rd_keep", 32'(cpuRData), 32'h5A);
    step();
    cpuReq = 1; cpuWe = 0; cpuAddr = 13'h1FFF;
    step(); step();
    chk("r035_readback", 32'(cpuRData), 32'hA5);

    // Simultaneous requests: video first
    wait_idle();
    cpuReq = 1; cpuWe = 0; cpuAddr = 13'h0200;
    vidReq = 1; vidAddr = 13'h0040;
    step();
    chk("r036_vaddr", 32'(memAddr), 32'h0040);
    step();
    chk("r036_vack", 32'(vidAck), 32'd1);
    chk("r036_cack0", 32'(cpuAck), 32'd0);
    step();
    chk("r036_idle", 32'(memCe), 32'd0);
    step();
    chk("r036_caddr", 32'(memAddr), 32'h0200);
    step();
    chk("r036_cack", 32'(cpuAck), 32'd1);

    // Starvation limit, twice to show the counter restarts after the CPU grant
    wait_idle();
    keep_vid = 1; vidReq = 1; vidAddr = 13'h0100;
    for (int r = 0; r < 2; r++) begin
      cpuReq = 1; cpuWe = 0; cpuAddr = 13'h1800;
      for (int k = 0; k <= LIM; k++) begin
        logic [AW-1:0] want;
        want = (k < LIM) ? vidAddr : 13'h1800;
        step();
        chk("r037_grant", 32'(memAddr), 32'(want));
        step(); step();
      end
    end
    keep_vid = 0; vidReq = 0;

    // Reset during a CPU access
    wait_idle();
    cpuReq = 1; cpuWe = 0; cpuAddr = 13'h0123;
    step();
    chk("r038_ce", 32'(memCe), 32'd1);
    do_reset("r038");
    for (int i = 0; i < 3; i++) begin
      step();
      chk("r038_noack", 32'(cpuAck), 32'd0);
      chk("r038_noce", 32'(memCe), 32'd0);
    end

    // Video alone, back to back
    wait_idle();
    keep_vid = 1; vidReq = 1; vidAddr = 13'h0000;
    for (int k = 0; k < 3; k++) begin
      step(); step();
      chk("r039_ack", 32'(vidAck), 32'd1);
      chk("r039_rd", 32'(vidRData), 32'(init_val(k)));
      step();
    end
    vidReq = 0; keep_vid = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset("rrst");
      keep_vid = 1'($urandom_range(0, 1));
      if (!cpuReq) begin
        if ($urandom_range(0, 2) == 0) begin
          cpuReq = 1; cpuWe = 1'($urandom_range(0, 1));
          cpuAddr = 13'($urandom_range(0, 31)); cpuWData = 8'($urandom);
        end
      end else if (have && !own_vid && cyc == g_edge) begin
        cpuAddr = 13'($urandom); cpuWData = 8'($urandom);
        cpuWe = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) cpuReq = 0;
      end
      if (!vidReq) begin
        if ($urandom_range(0, 1) == 0) begin
          vidReq = 1; vidAddr = 13'($urandom_range(0, 63));
        end
      end else if (have && own_vid && cyc == g_edge) begin
        vidAddr = 13'($urandom);
        if ($urandom_range(0, 3) == 0) vidReq = 0;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, video RAM address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width.
REQ-003 SHALL have parameter STARVE_LIMIT, default 4, consecutive video grants tolerated while CPU waits.
REQ-004 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port cpuReq  input  1  CPU access request, held high until cpuAck.
REQ-007 SHALL have port cpuWe  input  1  1 = write, 0 = read, valid while cpuReq high.
REQ-008 SHALL have port cpuAddr  input  ADDR_W  CPU address.
REQ-009 SHALL have port cpuWData  input  DATA_W  CPU write data.
REQ-010 SHALL have port cpuRData  output  DATA_W  CPU read data.
REQ-011 SHALL have port cpuAck  output  1  one-cycle completion pulse to CPU.
REQ-012 SHALL have port vidReq  input  1  video fetch request, held high until vidAck.
REQ-013 SHALL have port vidAddr  input  ADDR_W  video fetch address.
REQ-014 SHALL have port vidRData  output  DATA_W  video read data.
REQ-015 SHALL have port vidAck  output  1  one-cycle completion pulse to video fetch.
REQ-016 SHALL have ports memCe, memWe  output  1 each  RAM chip enable and write enable.
REQ-017 SHALL have ports memAddr  output  ADDR_W, memWData  output  DATA_W, memRData  input  DATA_W; RAM is synchronous, read data valid the cycle after memCe.

Function
REQ-018 SHALL implement FSM states IDLE, ACCESS, ACK; each access is ACCESS then ACK (2 cycles), grant decided only in IDLE.
REQ-019 IDLE: no request -> stay; a request present -> latch owner (VID/CPU), go ACCESS next edge.
REQ-020 Priority: video wins when both request, unless starveCnt == STARVE_LIMIT, then CPU wins.
REQ-021 starveCnt SHALL increment (saturating at STARVE_LIMIT) on each video grant while cpuReq high, and clear on CPU grant or whenever cpuReq low in IDLE.
REQ-022 ACCESS: memCe=1, memAddr=owner address; CPU write: memWe=1, memWData=cpuWData, for exactly this cycle; otherwise memWe=0.
REQ-023 ACCESS -> ACK unconditionally; ACK -> IDLE unconditionally.
REQ-024 ACK: owner's ack=1 for exactly one cycle; the other ack stays 0.
REQ-025 Read ACK: owner's RData SHALL equal memRData during ACK and hold that value afterwards until that owner's next read ACK.
REQ-026 CPU write ACK SHALL NOT change cpuRData.
REQ-027 Outside ACCESS: memCe=0, memWe=0, memAddr and memWData=0.
REQ-028 Request inputs (address, data, cpuWe) SHALL be sampled at the IDLE->ACCESS edge and held internally; changes afterwards do not affect the access.
REQ-029 Requester dropping req mid-access SHALL NOT abort: access completes, ack still pulses.
REQ-030 Back-to-back single requester: one access every 3 cycles (IDLE, ACCESS, ACK).

Reset
REQ-031 reset=0 SHALL immediately force state IDLE, starveCnt 0, all outputs 0 (cpuAck, vidAck, memCe, memWe, memAddr, memWData, cpuRData, vidRData).
REQ-032 Reset during ACCESS or ACK SHALL abort the access; no ack pulse after release.
REQ-033 First grant SHALL occur at the first rising edge with reset=1 and a request present.

Verification
REQ-034 CPU read alone, cpuAddr 0x0123, RAM[0x0123]=0x5A, req at cycle 0 -> memCe=1, memAddr=0x0123 cycle 1; cpuAck=1, cpuRData=0x5A cycle 2; cpuRData stays 0x5A afterwards.
REQ-035 CPU write cpuAddr 0x1FFF data 0xA5 -> memWe=1 only in cycle 1, cpuAck cycle 2; subsequent read of 0x1FFF returns 0xA5, cpuRData unchanged by the write.
REQ-036 cpuReq and vidReq rise together (cycle 0) -> video ACCESS cycle 1, vidAck cycle 2; CPU ACCESS cycle 4, cpuAck cycle 5.
REQ-037 vidReq continuously re-asserted, cpuReq held -> four video grants, then the fifth grant goes to CPU; starveCnt back to 0 after the CPU grant.
REQ-038 reset pulled low during CPU ACCESS -> all outputs 0 asynchronously; after release with no requests: no cpuAck, memCe stays 0.
REQ-039 vidReq alone held with addresses 0x0000, 0x0001, ... -> vidAck at cycles 2, 5, 8, with vidRData matching RAM contents.
